mem_access_stage: RTL

- Memory-access stage of the predicated pipeline; sits between the EX/MEM pipeline register and the MEM/WB register.
- Performs predicated load/store over a ready-handshake data-memory port and stalls upstream while an access is outstanding.
- Presents the stage result (load data or ALU result), destination register, write enable, predicate and RegSel to MEM/WB; presents a bubble while stalled.

---
 rtl/mem_access_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access stage of the predicated pipeline.
// Sits between EX/MEM and MEM/WB. Non-memory instructions pass straight
// through with no added latency; predicated-on, aligned loads/stores run a
// three-state sequence (IDLE -> ACCESS -> DONE) against a ready-handshake
// data-memory port while holding the upstream stages with stall_mem.
//
// Handshake: dmem_req is decoded from the registered state and is high for
// every ACCESS cycle. Address, write enable and store data are stable for the
// whole request because EX/MEM is frozen by stall_mem. The memory completes
// the access by raising dmem_ready for one cycle (with dmem_rdata valid for a
// load); dmem_ready seen in any other state is ignored.
module mem_access_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  // From EX/MEM
  input  logic              Predicate_ex,
  input  logic [DATA_W-1:0] ALURes_ex,
  input  logic [DATA_W-1:0] StoreData_ex,
  input  logic [REG_AW-1:0] RW_ex,
  input  logic              RegWrite_ex,
  input  logic              RegSel_ex,
  input  logic              MemRead_ex,
  input  logic              MemWrite_ex,
  // To MEM/WB
  output logic              Predicate_mem,
  output logic [DATA_W-1:0] Res_mem,
  output logic [REG_AW-1:0] RW_mem,
  output logic              RegWrite_mem,
  output logic              RegSel_mem,
  // Pipeline control and status
  output logic              stall_mem,
  output logic              mem_err,
  // Data-memory port
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  // Debug visibility of the FSM state (IDLE=0, ACCESS=1, DONE=2)
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Last counter value before the access is abandoned. Only meaningful when
  // TIMEOUT is non-zero; a zero TIMEOUT disables the check entirely.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;       // current access timed out
  logic              mem_err_q, mem_err_d; // sticky until reset

  logic memop;
  logic misaligned;
  logic timeout_hit;

  // A memory operation only counts when its predicate is true; a
  // predicated-off load/store behaves exactly like an ALU op.
  assign memop       = (MemRead_ex | MemWrite_ex) & Predicate_ex;
  assign misaligned  = memop & (ALURes_ex[1:0] != 2'b00);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  assign mem_err   = mem_err_q;
  assign state_dbg = state_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state logic: sequencing, wait counting, load capture and errors.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    mem_err_d = mem_err_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          if (misaligned) begin
            // Misaligned access is dropped; only the sticky flag records it.
            mem_err_d = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A completion in the same cycle as the timeout wins.
        if (dmem_ready) begin
          if (MemRead_ex) begin
            rdata_d = dmem_rdata;
          end
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d     = 1'b1;
          mem_err_d = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: pass-through, bubble, memory request or result, all held
  // at zero while reset is asserted.
  always_comb begin
    stall_mem     = 1'b0;
    Predicate_mem = 1'b0;
    Res_mem       = '0;
    RW_mem        = '0;
    RegWrite_mem  = 1'b0;
    RegSel_mem    = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_wdata    = '0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (!memop) begin
            Predicate_mem = Predicate_ex;
            Res_mem       = ALURes_ex;
            RW_mem        = RW_ex;
            RegWrite_mem  = RegWrite_ex;
            RegSel_mem    = RegSel_ex;
          end else if (!misaligned) begin
            // Aligned access starts: hold upstream, emit a bubble.
            stall_mem = 1'b1;
          end
          // Misaligned: bubble with no stall, the instruction retires.
        end
        ACCESS: begin
          stall_mem  = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = MemWrite_ex;
          dmem_addr  = ALURes_ex;
          dmem_wdata = StoreData_ex;
        end
        DONE: begin
          Predicate_mem = 1'b1;
          RW_mem        = RW_ex;
          RegSel_mem    = RegSel_ex;
          RegWrite_mem  = RegWrite_ex & MemRead_ex & ~err_q;
          if (err_q) begin
            Res_mem = '0;
          end else if (MemRead_ex) begin
            Res_mem = rdata_q;
          end else begin
            Res_mem = ALURes_ex;
          end
        end
        default: begin
          stall_mem = 1'b0;
        end
      endcase
    end
  end

endmodule
